// File: rtl/fifo_lane_compact.sv
// Prefix-AND lane compaction: a lane is accepted only if it and every lower lane are
// requested and allowed. Also returns how many lanes were accepted.
module fifo_lane_compact #(
    parameter int N = 2
) (
    input  logic [N-1:0]             req_i,
    input  logic [N-1:0]             allow_i,
    output logic [N-1:0]             acc_o,
    output logic [$clog2(N+1)-1:0]   cnt_o
);

    localparam int CW = $clog2(N + 1);

    logic run;

    always_comb begin
        run   = 1'b1;
        acc_o = '0;
        cnt_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            run      = run & req_i[k] & allow_i[k];
            acc_o[k] = run;
            cnt_o    = cnt_o + CW'(run);
        end
    end

endmodule

// File: rtl/fifo_mimo.sv
// Multi-write / multi-read in-order FIFO on a flop array; head R_PORTS entries are
// presented combinationally, and writes become visible one cycle later.
module fifo_mimo #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int W_PORTS = 2,
    parameter int R_PORTS = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [W_PORTS-1:0]           i_w_e,
    input  logic [W_PORTS*WIDTH-1:0]     i_w_data,
    output logic [W_PORTS-1:0]           o_w_ready,
    output logic [W_PORTS-1:0]           o_w_ack,
    output logic [R_PORTS-1:0]           o_r_valid,
    output logic [R_PORTS*WIDTH-1:0]     o_r_data,
    input  logic [R_PORTS-1:0]           i_r_e,
    output logic [R_PORTS-1:0]           o_r_ack,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int NW_W  = $clog2(W_PORTS + 1);
    localparam int NR_W  = $clog2(R_PORTS + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   w_ptr_q, w_ptr_d;
    logic [PTR_W-1:0]   r_ptr_q, r_ptr_d;
    logic [W_PORTS-1:0] w_ack_q;
    logic [R_PORTS-1:0] r_ack_q;

    logic [CNT_W-1:0]   free;
    logic [W_PORTS-1:0] w_acc;
    logic [R_PORTS-1:0] r_acc;
    logic [NW_W-1:0]    nw;
    logic [NR_W-1:0]    nr;

    // Free space is taken from the cycle-start count only, so same-cycle pops never admit writes.
    always_comb begin
        free      = CNT_W'(DEPTH) - count_q;
        o_w_ready = '0;
        o_r_valid = '0;
        o_r_data  = '0;
        for (int unsigned k = 0; k < W_PORTS; k++) begin
            o_w_ready[k] = free > CNT_W'(k);
        end
        for (int unsigned k = 0; k < R_PORTS; k++) begin
            o_r_valid[k]                = count_q > CNT_W'(k);
            o_r_data[k*WIDTH +: WIDTH]  = mem_q[r_ptr_q + PTR_W'(k)];
        end
    end

    fifo_lane_compact #(.N(W_PORTS)) u_w_compact (
        .req_i   (i_w_e),
        .allow_i (o_w_ready),
        .acc_o   (w_acc),
        .cnt_o   (nw)
    );

    fifo_lane_compact #(.N(R_PORTS)) u_r_compact (
        .req_i   (i_r_e),
        .allow_i (o_r_valid),
        .acc_o   (r_acc),
        .cnt_o   (nr)
    );

    always_comb begin
        count_d = count_q + CNT_W'(nw) - CNT_W'(nr);
        w_ptr_d = w_ptr_q + PTR_W'(nw);
        r_ptr_d = r_ptr_q + PTR_W'(nr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            w_ack_q <= '0;
            r_ack_q <= '0;
        end else if (i_flush) begin
            count_q <= '0;
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            w_ack_q <= '0;
            r_ack_q <= '0;
        end else begin
            count_q <= count_d;
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            w_ack_q <= w_acc;
            r_ack_q <= r_acc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_flush) begin
            for (int unsigned k = 0; k < W_PORTS; k++) begin
                if (w_acc[k]) begin
                    mem_q[w_ptr_q + PTR_W'(k)] <= i_w_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign o_w_ack = w_ack_q;
    assign o_r_ack = r_ack_q;
    assign o_count = count_q;
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);

endmodule

// File: tb/tb_fifo_mimo.sv
// Randomized and directed check of fifo_mimo against a queue-based reference model.
module tb_fifo_mimo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int WP    = 2;
    localparam int RP    = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [WP-1:0]     i_w_e;
    logic [WP*WIDTH-1:0] i_w_data;
    logic [WP-1:0]     o_w_ready;
    logic [WP-1:0]     o_w_ack;
    logic [RP-1:0]     o_r_valid;
    logic [RP*WIDTH-1:0] o_r_data;
    logic [RP-1:0]     i_r_e;
    logic [RP-1:0]     o_r_ack;
    logic              i_flush;
    logic [2:0]        o_count;
    logic              o_full;
    logic              o_empty;

    always #5 i_clk = ~i_clk;

    fifo_mimo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .W_PORTS (WP),
        .R_PORTS (RP)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_w_e     (i_w_e),
        .i_w_data  (i_w_data),
        .o_w_ready (o_w_ready),
        .o_w_ack   (o_w_ack),
        .o_r_valid (o_r_valid),
        .o_r_data  (o_r_data),
        .i_r_e     (i_r_e),
        .o_r_ack   (o_r_ack),
        .i_flush   (i_flush),
        .o_count   (o_count),
        .o_full    (o_full),
        .o_empty   (o_empty)
    );

    logic [WIDTH-1:0] model_q [$];
    logic [WP-1:0]    exp_wack;
    logic [RP-1:0]    exp_rack;
    int               n_chk;
    int               n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = model_q.size();
        chk("count", 32'(o_count), 32'(sz));
        chk("full",  32'(o_full),  32'(sz == DEPTH));
        chk("empty", 32'(o_empty), 32'(sz == 0));
        for (int k = 0; k < WP; k++)
            chk($sformatf("w_ready%0d", k), 32'(o_w_ready[k]), 32'((DEPTH - sz) > k));
        for (int k = 0; k < RP; k++) begin
            chk($sformatf("r_valid%0d", k), 32'(o_r_valid[k]), 32'(sz > k));
            if (k < sz)
                chk($sformatf("r_data%0d", k), 32'(o_r_data[k*WIDTH +: WIDTH]), 32'(model_q[k]));
        end
        chk("w_ack", 32'(o_w_ack), 32'(exp_wack));
        chk("r_ack", 32'(o_r_ack), 32'(exp_rack));
    endtask

    task automatic step(input logic [WP-1:0] we, input logic [WP*WIDTH-1:0] wd,
                        input logic [RP-1:0] re, input logic fl);
        int            free;
        int            sz;
        logic          run;
        logic [WP-1:0] wacc;
        logic [RP-1:0] racc;
        @(negedge i_clk);
        i_w_e    = we;
        i_w_data = wd;
        i_r_e    = re;
        i_flush  = fl;
        #1;
        check_outputs();
        sz   = model_q.size();
        free = DEPTH - sz;
        run  = 1'b1;
        for (int k = 0; k < WP; k++) begin
            run     = run && we[k] && (free > k);
            wacc[k] = run;
        end
        run = 1'b1;
        for (int k = 0; k < RP; k++) begin
            run     = run && re[k] && (sz > k);
            racc[k] = run;
        end
        if (fl) begin
            model_q.delete();
            exp_wack = '0;
            exp_rack = '0;
        end else begin
            for (int k = 0; k < RP; k++)
                if (racc[k]) void'(model_q.pop_front());
            for (int k = 0; k < WP; k++)
                if (wacc[k]) model_q.push_back(wd[k*WIDTH +: WIDTH]);
            exp_wack = wacc;
            exp_rack = racc;
        end
        @(posedge i_clk);
    endtask

    task automatic async_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        model_q.delete();
        exp_wack = '0;
        exp_rack = '0;
        check_outputs();
        #2;
        i_rst_n = 1'b1;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        exp_wack = '0;
        exp_rack = '0;
        i_rst_n  = 1'b0;
        i_w_e    = '0;
        i_w_data = '0;
        i_r_e    = '0;
        i_flush  = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        step(2'b00, 16'h0000, 2'b00, 1'b0);
        step(2'b11, 16'hA2A1, 2'b00, 1'b0);
        step(2'b00, 16'h0000, 2'b00, 1'b0);
        step(2'b01, 16'h00A3, 2'b00, 1'b0);
        step(2'b11, 16'hB2B1, 2'b00, 1'b0);
        step(2'b00, 16'h0000, 2'b00, 1'b0);
        step(2'b11, 16'hC2C1, 2'b11, 1'b0);
        step(2'b11, 16'hD2D1, 2'b00, 1'b0);
        step(2'b11, 16'hE2E1, 2'b11, 1'b0);
        step(2'b11, 16'hF2F1, 2'b11, 1'b0);
        step(2'b00, 16'h0000, 2'b11, 1'b0);
        step(2'b00, 16'h0000, 2'b11, 1'b0);
        step(2'b00, 16'h0000, 2'b00, 1'b0);

        step(2'b11, 16'h1211, 2'b00, 1'b0);
        step(2'b01, 16'h0013, 2'b00, 1'b0);
        step(2'b11, 16'h1615, 2'b11, 1'b1);
        step(2'b01, 16'h0077, 2'b00, 1'b0);
        step(2'b00, 16'h0000, 2'b01, 1'b0);

        step(2'b10, 16'h5500, 2'b00, 1'b0);
        step(2'b00, 16'h0000, 2'b00, 1'b0);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset();
            step(2'($urandom), 16'($urandom), 2'($urandom), ($urandom_range(0, 31) == 0));
        end
        step(2'b00, 16'h0000, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
